// File: rtl/riscv_pkg.sv
// ============================================================================
//  Module   : riscv_pkg
//  Brief    : Shared RV32I fetch-side constants and the fetch FSM state type.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;
    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } fetch_state_e;
endpackage

`default_nettype wire

// File: rtl/if_fetch_queue.sv
// ============================================================================
//  Module   : if_fetch_queue
//  Brief    : In-order fetch queue; entries are reserved at request time and
//             filled by responses, head is presented to decode once filled.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fetch_queue
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            reserve,
    input  logic [XLEN-1:0] reserve_pc,
    input  logic            fill,
    input  logic [XLEN-1:0] fill_data,
    input  logic            pop,
    output logic            head_filled,
    output logic [XLEN-1:0] head_pc,
    output logic [XLEN-1:0] head_data,
    output logic [CW-1:0]   occupancy,
    output logic [CW-1:0]   unfilled
);
    localparam int PW = $clog2(DEPTH);

    logic [XLEN-1:0] r_pc_mem   [DEPTH];
    logic [XLEN-1:0] r_data_mem [DEPTH];
    logic [DEPTH-1:0] r_filled;
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [PW-1:0]   r_fill_ptr;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   r_unfilled;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_fill_ptr <= '0;
            r_count    <= '0;
            r_unfilled <= '0;
            r_filled   <= '0;
        end else if (flush) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_fill_ptr <= '0;
            r_count    <= '0;
            r_unfilled <= '0;
            r_filled   <= '0;
        end else begin
            if (reserve) r_tail     <= r_tail + PW'(1);
            if (fill)    r_fill_ptr <= r_fill_ptr + PW'(1);
            if (pop)     r_head     <= r_head + PW'(1);
            r_count    <= r_count + CW'(reserve) - CW'(pop);
            r_unfilled <= r_unfilled + CW'(reserve) - CW'(fill);
            // A popped head may be re-reserved in the same cycle when full; fill targets an older slot.
            if (pop)     r_filled[r_head]     <= 1'b0;
            if (reserve) r_filled[r_tail]     <= 1'b0;
            if (fill)    r_filled[r_fill_ptr] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reserve && !flush) r_pc_mem[r_tail] <= reserve_pc;
        if (fill && !flush)    r_data_mem[r_fill_ptr] <= fill_data;
    end

    assign head_filled = r_filled[r_head];
    assign head_pc     = r_pc_mem[r_head];
    assign head_data   = r_data_mem[r_head];
    assign occupancy   = r_count;
    assign unfilled    = r_unfilled;
endmodule

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
//  Module   : if_stage
//  Brief    : RV32I instruction-fetch stage: PC, imem request channel, drop
//             accounting after redirect. IF_PERF_CNT_EN adds fetch_count.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        instr_valid,
    output logic [31:0] instr,
`ifdef IF_PERF_CNT_EN
    output logic [31:0] fetch_count,
`endif
    output logic [31:0] pc_out
);
    localparam int            c_CW    = $clog2(FIFO_DEPTH + 1);
    localparam logic [c_CW:0] c_DEPTH = (c_CW + 1)'(FIFO_DEPTH);

    fetch_state_e    r_state;
    fetch_state_e    w_state_next;
    logic [31:0]     r_pc;
    logic [c_CW-1:0] r_drop_cnt;
    logic [c_CW-1:0] w_drop_next;
    logic [c_CW-1:0] w_drop_sum;
    logic [c_CW-1:0] w_occ;
    logic [c_CW-1:0] w_unfilled;
    logic [c_CW:0]   w_budget;
    logic            w_head_filled;
    logic [31:0]     w_head_pc;
    logic [31:0]     w_head_data;
    logic            w_pop;
    logic            w_fill;
    logic            w_reserve;

    assign w_pop = w_head_filled & ~stall & ~redirect_valid;

    // A slot freed by this cycle's pop may be re-issued at once, giving 1 instr/cycle.
    assign w_budget       = {1'b0, w_occ} + {1'b0, r_drop_cnt} - {{c_CW{1'b0}}, w_pop};
    assign imem_req_valid = reset_n & ~redirect_valid & (w_budget < c_DEPTH);
    assign imem_req_addr  = r_pc;
    assign w_reserve      = imem_req_valid & imem_req_ready;
    assign w_fill         = imem_rsp_valid & (r_state == RUN) & ~redirect_valid;
    assign w_drop_sum     = r_drop_cnt + w_unfilled - c_CW'(imem_rsp_valid);

    always_comb begin
        w_state_next = r_state;
        w_drop_next  = r_drop_cnt;
        if (redirect_valid) begin
            w_drop_next  = w_drop_sum;
            w_state_next = (w_drop_sum != '0) ? FLUSH : RUN;
        end else begin
            case (r_state)
                RUN: begin
                    w_state_next = RUN;
                end
                FLUSH: begin
                    if (imem_rsp_valid) begin
                        w_drop_next = r_drop_cnt - c_CW'(1);
                        if (r_drop_cnt == c_CW'(1)) w_state_next = RUN;
                    end
                end
                default: w_state_next = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= RUN;
            r_drop_cnt <= '0;
            r_pc       <= RESET_PC;
        end else begin
            r_state    <= w_state_next;
            r_drop_cnt <= w_drop_next;
            if (redirect_valid) r_pc <= redirect_pc & ~32'h3;
            else if (w_reserve) r_pc <= r_pc + PC_STEP;
        end
    end

    if_fetch_queue #(
        .DEPTH (FIFO_DEPTH),
        .CW    (c_CW)
    ) u_queue (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (redirect_valid),
        .reserve     (w_reserve),
        .reserve_pc  (r_pc),
        .fill        (w_fill),
        .fill_data   (imem_rsp_data),
        .pop         (w_pop),
        .head_filled (w_head_filled),
        .head_pc     (w_head_pc),
        .head_data   (w_head_data),
        .occupancy   (w_occ),
        .unfilled    (w_unfilled)
    );

    assign instr_valid = w_head_filled;
    assign instr       = w_head_filled ? w_head_data : NOP_INSTR;
    assign pc_out      = w_head_filled ? w_head_pc : 32'h0;

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_fetch_count;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)   r_fetch_count <= '0;
        else if (w_pop) r_fetch_count <= r_fetch_count + 32'd1;
    end
    assign fetch_count = r_fetch_count;
`endif

`ifndef SYNTHESIS
    a_rsp_has_slot: assert property (@(posedge clk) disable iff (!reset_n)
        imem_rsp_valid |-> ((r_state == FLUSH) ? (r_drop_cnt != '0) : (w_unfilled != '0)));
`endif
endmodule

`default_nettype wire
